control_sequencer: RTL and testbench



---
 rtl/cpu_defs.sv | 61 ++++++
 rtl/control_sequencer_reg_select.sv | 22 ++
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control unit: opcode values,
// sequencer state encoding, IR field positions and an opcode classifier.
package cpu_defs;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // IR field positions (LSB of each field; fields are contiguous upward)
  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_LSB = 15;
  localparam int unsigned REG_W     = 4;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_BINARY,
    CL_MULDIV,
    CL_UNARY,
    CL_HALT
  } op_class_e;

  function automatic op_class_e classify(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: classify = CL_BINARY;
      OP_MUL, OP_DIV:                  classify = CL_MULDIV;
      OP_NEG, OP_NOT:                  classify = CL_UNARY;
      OP_HALT:                         classify = CL_HALT;
      default:                         classify = CL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// Register-number to one-hot enable decoder.
// Ports: sel    - register number
//        en     - decode enable; when low the output is all zero
//        onehot - NUM_REGS-wide one-hot enable (bit index = register number)
module reg_select
  import cpu_defs::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [REG_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (sel == REG_W'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the datapath: fetches via PC/MAR/MDR/IR,
// decodes IR in T3 and sequences ALU-class register transfers.
// Ports: Clock, clear (sync, active-low), IR, Mem_ready (T1 wait), Stop
//        (halt request sampled on every T0 entry), bus-drive and load
//        strobes, IncPC/Read, one-hot Rin/Rout, alu_op, Run.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OPW      = 5
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic [31:0]         IR,
  input  logic                Mem_ready,
  input  logic                Stop,
  output logic                PCout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPW-1:0]      alu_op,
  output logic                Run
);

  state_e           state;
  logic [OPW-1:0]   op;
  logic [REG_W-1:0] ra, rb, rc;
  op_class_e        cls;
  state_e           after_instr;

  logic             rin_en, rout_en;
  logic [REG_W-1:0] rin_sel, rout_sel;

  // Low IR bits carry immediates the sequencer never looks at.
  logic unused_ir;
  assign unused_ir = ^IR[IR_RC_LSB-1:0];

  assign op  = IR[IR_OP_LSB +: OPW];
  assign ra  = IR[IR_RA_LSB +: REG_W];
  assign rb  = IR[IR_RB_LSB +: REG_W];
  assign rc  = IR[IR_RC_LSB +: REG_W];
  assign cls = classify(op[OP_W-1:0]);

  // Every return to T0 is a Stop sampling point.
  assign after_instr = Stop ? S_HALT : S_T0;

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= after_instr;
        S_T0:    state <= S_T1;
        S_T1:    state <= Mem_ready ? S_T2 : S_T1;
        S_T2:    state <= S_T3;
        S_T3:
          case (cls)
            CL_BINARY, CL_MULDIV, CL_UNARY: state <= S_T4;
            CL_HALT:                        state <= S_HALT;
            default:                        state <= after_instr;
          endcase
        S_T4:    state <= (cls == CL_UNARY) ? after_instr : S_T5;
        S_T5:    state <= (cls == CL_MULDIV) ? S_T6 : after_instr;
        S_T6:    state <= after_instr;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // IR is loaded at the end of T2, so T3 onward is decoded from the live IR
  // rather than from a register stage that would see the previous value.
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; PCin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    alu_op = '0;
    rin_en = 1'b0; rin_sel = '0;
    rout_en = 1'b0; rout_sel = '0;
    Run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
      end
      S_T1: begin
        Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3:
        case (cls)
          CL_BINARY: begin rout_en = 1'b1; rout_sel = rb; Yin = 1'b1; end
          CL_MULDIV: begin rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; end
          CL_UNARY: begin
            rout_en = 1'b1; rout_sel = rb; Zin = 1'b1; alu_op = op;
          end
          default: ;
        endcase
      S_T4:
        case (cls)
          CL_BINARY: begin
            rout_en = 1'b1; rout_sel = rc; Zin = 1'b1; alu_op = op;
          end
          CL_MULDIV: begin
            rout_en = 1'b1; rout_sel = rb; Zin = 1'b1; alu_op = op;
          end
          CL_UNARY: begin Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ra; end
          default: ;
        endcase
      S_T5:
        case (cls)
          CL_BINARY: begin Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ra; end
          CL_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          default: ;
        endcase
      S_T6:
        if (cls == CL_MULDIV) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
      default: ;
    endcase
  end

  reg_select #(.NUM_REGS(NUM_REGS)) u_rin (
    .sel    (rin_sel),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_select #(.NUM_REGS(NUM_REGS)) u_rout (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        Stop;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        Run;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe bundle bit positions
  localparam logic [15:0] B_PCOUT    = 16'h8000;
  localparam logic [15:0] B_ZHIGHOUT = 16'h4000;
  localparam logic [15:0] B_ZLOWOUT  = 16'h2000;
  localparam logic [15:0] B_MDROUT   = 16'h1000;
  localparam logic [15:0] B_PCIN     = 16'h0200;
  localparam logic [15:0] B_MARIN    = 16'h0100;
  localparam logic [15:0] B_MDRIN    = 16'h0080;
  localparam logic [15:0] B_IRIN     = 16'h0040;
  localparam logic [15:0] B_YIN      = 16'h0020;
  localparam logic [15:0] B_ZIN      = 16'h0010;
  localparam logic [15:0] B_HIIN     = 16'h0008;
  localparam logic [15:0] B_LOIN     = 16'h0004;
  localparam logic [15:0] B_INCPC    = 16'h0002;
  localparam logic [15:0] B_READ     = 16'h0001;

  localparam logic [15:0] ST_T0 = B_PCOUT | B_MARIN | B_INCPC | B_PCIN;
  localparam logic [15:0] ST_T1 = B_READ | B_MDRIN;
  localparam logic [15:0] ST_T2 = B_MDROUT | B_IRIN;

  logic [15:0] strb;
  assign strb = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                 PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read};

  control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
    .Run(Run)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait to the falling edge and compare every output against expectation.
  task automatic cyc(input string tag, input logic [15:0] e_strb,
                     input logic [15:0] e_rin, input logic [15:0] e_rout,
                     input logic [4:0] e_op, input logic e_run);
    @(negedge Clock);
    check({tag, ".strb"}, 32'(strb),   32'(e_strb));
    check({tag, ".rin"},  32'(Rin),    32'(e_rin));
    check({tag, ".rout"}, 32'(Rout),   32'(e_rout));
    check({tag, ".alu"},  32'(alu_op), 32'(e_op));
    check({tag, ".run"},  32'(Run),    32'(e_run));
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op,
      input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    mk_ir = {op, ra, rb, rc, 15'h0};
  endfunction

  // Fetch with no memory wait; IR is updated at the end of T2.
  task automatic fetch(input string tag, input logic [31:0] ir);
    cyc({tag, ".T0"}, ST_T0, '0, '0, '0, 1'b1);
    cyc({tag, ".T1"}, ST_T1, '0, '0, '0, 1'b1);
    cyc({tag, ".T2"}, ST_T2, '0, '0, '0, 1'b1);
    IR = ir;
  endtask

  task automatic do_reset(input string tag);
    clear = 1'b0;
    cyc({tag, ".r"}, '0, '0, '0, '0, 1'b0);
    clear = 1'b1;
  endtask

  initial begin
    clear = 1'b0; IR = '0; Mem_ready = 1'b1; Stop = 1'b0;

    // Reset held for two cycles
    cyc("rst0", '0, '0, '0, '0, 1'b0);
    cyc("rst1", '0, '0, '0, '0, 1'b0);
    clear = 1'b1;

    // AND R1,R2,R3
    fetch("and", 32'h2891_8000);
    cyc("and.T3", B_YIN,                 '0,       16'h0004, '0,       1'b1);
    cyc("and.T4", B_ZIN,                 '0,       16'h0008, 5'b00101, 1'b1);
    cyc("and.T5", B_ZLOWOUT,             16'h0002, '0,       '0,       1'b1);

    // Memory wait of three edges, then MUL R2,R3
    cyc("mw.T0", ST_T0, '0, '0, '0, 1'b1);
    Mem_ready = 1'b0;
    cyc("mw.T1a", ST_T1, '0, '0, '0, 1'b1);
    cyc("mw.T1b", ST_T1, '0, '0, '0, 1'b1);
    cyc("mw.T1c", ST_T1, '0, '0, '0, 1'b1);
    cyc("mw.T1d", ST_T1, '0, '0, '0, 1'b1);
    Mem_ready = 1'b1;
    cyc("mw.T2", ST_T2, '0, '0, '0, 1'b1);
    IR = 32'h7918_0000;
    cyc("mul.T3", B_YIN,                  '0, 16'h0004, '0,       1'b1);
    cyc("mul.T4", B_ZIN,                  '0, 16'h0008, 5'b01111, 1'b1);
    cyc("mul.T5", B_ZLOWOUT | B_LOIN,     '0, '0,       '0,       1'b1);
    cyc("mul.T6", B_ZHIGHOUT | B_HIIN,    '0, '0,       '0,       1'b1);

    // NEG R5,R7 (unary)
    fetch("neg", mk_ir(5'b10001, 4'd5, 4'd7, 4'd0));
    cyc("neg.T3", B_ZIN,     '0,       16'h0080, 5'b10001, 1'b1);
    cyc("neg.T4", B_ZLOWOUT, 16'h0020, '0,       '0,       1'b1);

    // NOP and an undefined opcode: T3 silent, then straight back to fetch
    fetch("nop", mk_ir(5'b11010, 4'd1, 4'd2, 4'd3));
    cyc("nop.T3", '0, '0, '0, '0, 1'b1);
    fetch("undef", mk_ir(5'b11111, 4'd1, 4'd2, 4'd3));
    cyc("undef.T3", '0, '0, '0, '0, 1'b1);

    // OR R0,R4,R15 with Stop raised during T5
    fetch("or", mk_ir(5'b00110, 4'd0, 4'd4, 4'd15));
    cyc("or.T3", B_YIN,     '0,       16'h0010, '0,       1'b1);
    cyc("or.T4", B_ZIN,     '0,       16'h8000, 5'b00110, 1'b1);
    cyc("or.T5", B_ZLOWOUT, 16'h0001, '0,       '0,       1'b1);
    Stop = 1'b1;
    cyc("stop.h0", '0, '0, '0, '0, 1'b0);
    Stop = 1'b0;
    cyc("stop.h1", '0, '0, '0, '0, 1'b0);
    do_reset("stop");
    cyc("stop.T0", ST_T0, '0, '0, '0, 1'b1);
    cyc("stop.T1", ST_T1, '0, '0, '0, 1'b1);
    cyc("stop.T2", ST_T2, '0, '0, '0, 1'b1);

    // HALT opcode: Run drops and stays low
    IR = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
    cyc("halt.T3", '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cyc($sformatf("halt.h%0d", i), '0, '0, '0, '0, 1'b0);
    do_reset("halt");

    // SUB R6,R1,R2 interrupted by clear during T4
    fetch("sub", mk_ir(5'b00100, 4'd6, 4'd1, 4'd2));
    cyc("sub.T3", B_YIN, '0, 16'h0002, '0,       1'b1);
    cyc("sub.T4", B_ZIN, '0, 16'h0004, 5'b00100, 1'b1);
    clear = 1'b0;
    cyc("sub.rst", '0, '0, '0, '0, 1'b0);
    clear = 1'b1;
    cyc("sub.T0", ST_T0, '0, '0, '0, 1'b1);
    cyc("sub.T1", ST_T1, '0, '0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
